led_rgb_pattern_sequencer: RTL and testbench

//   Steps the led_rgb core through a programmable table of colour patterns.

---
 rtl/led_rgb_pattern_sequencer_if.sv | 31 +++
 rtl/led_rgb_pattern_sequencer.sv | 177 +++++++++++++++++
 tb/tb_led_rgb_pattern_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_rgb_pattern_sequencer_if.sv
// Table-write bus from the register block into the LED pattern sequencer.
// The register block drives the master side; the sequencer receives on the slave side.
interface led_rgb_pattern_sequencer_if #(
  parameter int AW   = 4,
  parameter int DW_W = 32
);
  logic            tbl_wr;
  logic [AW-1:0]   tbl_addr;
  logic [2:0]      tbl_en;
  logic [2:0]      tbl_mode;
  logic [DW_W-1:0] tbl_duration;
  logic [DW_W-1:0] tbl_dwell;

  modport master (
    output tbl_wr,
    output tbl_addr,
    output tbl_en,
    output tbl_mode,
    output tbl_duration,
    output tbl_dwell
  );

  modport slave (
    input tbl_wr,
    input tbl_addr,
    input tbl_en,
    input tbl_mode,
    input tbl_duration,
    input tbl_dwell
  );
endinterface

// File: rtl/led_rgb_pattern_sequencer.sv
// Steps the led_rgb core through a programmable table of colour patterns.
// Optional LED_SEQ_PAUSE_EN adds pause_i, which freezes the dwell timer while in RUN.
//
// state | meaning
// IDLE  | waiting for start_i; outputs hold last entry (zero after reset/stop)
// LOAD  | one cycle reading entry idx_q; outputs still show the previous entry
// RUN   | entry driven; dwell down-counter runs to terminal count zero
module led_rgb_pattern_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW_W  = 32
) (
  input  logic                       aclk_i,
  input  logic                       aresetn_i,
  led_rgb_pattern_sequencer_if.slave tbl_if,
  input  logic [AW:0]                num_steps_i,
  input  logic                       loop_en_i,
  input  logic                       start_i,
  input  logic                       stop_i,
`ifdef LED_SEQ_PAUSE_EN
  input  logic                       pause_i,
`endif
  output logic [2:0]                 enable_rgb_o,
  output logic [2:0]                 mode_rgb_o,
  output logic [DW_W-1:0]            duration_o,
  output logic [AW-1:0]              step_idx_o,
  output logic                       busy_o,
  output logic                       done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW:0]     nsteps_q, nsteps_d;
  logic [DW_W-1:0] cnt_q, cnt_d;
  logic [2:0]      en_q, en_d;
  logic [2:0]      mode_q, mode_d;
  logic [DW_W-1:0] dur_q, dur_d;
  logic [AW-1:0]   step_q, step_d;
  logic            done_q, done_d;

  logic [2:0]      tbl_en_q   [DEPTH];
  logic [2:0]      tbl_mode_q [DEPTH];
  logic [DW_W-1:0] tbl_dur_q  [DEPTH];
  logic [DW_W-1:0] tbl_dwell_q[DEPTH];

  logic [2:0]      rd_en, rd_mode;
  logic [DW_W-1:0] rd_dur, rd_dwell;
  logic            run_hold;
  logic            cnt_tc;
  logic            last_step;

`ifdef LED_SEQ_PAUSE_EN
  assign run_hold = pause_i;
`else
  assign run_hold = 1'b0;
`endif

  // Table has no reset; contents are only meaningful once software writes them.
  always_ff @(posedge aclk_i) begin
    if (tbl_if.tbl_wr) begin
      tbl_en_q[tbl_if.tbl_addr]    <= tbl_if.tbl_en;
      tbl_mode_q[tbl_if.tbl_addr]  <= tbl_if.tbl_mode;
      tbl_dur_q[tbl_if.tbl_addr]   <= tbl_if.tbl_duration;
      tbl_dwell_q[tbl_if.tbl_addr] <= tbl_if.tbl_dwell;
    end
  end

  assign rd_en     = tbl_en_q[idx_q];
  assign rd_mode   = tbl_mode_q[idx_q];
  assign rd_dur    = tbl_dur_q[idx_q];
  assign rd_dwell  = tbl_dwell_q[idx_q];

  assign cnt_tc    = (cnt_q == '0);
  assign last_step = (({1'b0, idx_q} + (AW+1)'(1)) == nsteps_q);

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      nsteps_q <= '0;
      cnt_q    <= '0;
      en_q     <= '0;
      mode_q   <= '0;
      dur_q    <= '0;
      step_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nsteps_q <= nsteps_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      dur_q    <= dur_d;
      step_q   <= step_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    nsteps_d = nsteps_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    mode_d   = mode_q;
    dur_d    = dur_q;
    step_d   = step_q;
    done_d   = 1'b0;

    // stop outranks everything, including a same-cycle start and pause
    if (stop_i) begin
      state_d = S_IDLE;
      idx_d   = '0;
      en_d    = '0;
      mode_d  = '0;
      dur_d   = '0;
      step_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (num_steps_i == '0) begin
              done_d = 1'b1;
            end else begin
              nsteps_d = num_steps_i;
              idx_d    = '0;
              state_d  = S_LOAD;
            end
          end
        end

        S_LOAD: begin
          en_d    = rd_en;
          mode_d  = rd_mode;
          dur_d   = rd_dur;
          step_d  = idx_q;
          cnt_d   = (rd_dwell == '0) ? '0 : rd_dwell - DW_W'(1);
          state_d = S_RUN;
        end

        S_RUN: begin
          if (!run_hold) begin
            if (!cnt_tc) begin
              cnt_d = cnt_q - DW_W'(1);
            end else if (!last_step) begin
              idx_d   = idx_q + AW'(1);
              state_d = S_LOAD;
            end else if (loop_en_i) begin
              idx_d   = '0;
              state_d = S_LOAD;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign enable_rgb_o = en_q;
  assign mode_rgb_o   = mode_q;
  assign duration_o   = dur_q;
  assign step_idx_o   = step_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;

endmodule

// File: tb/tb_led_rgb_pattern_sequencer.sv
// Directed self-checking bench for led_rgb_pattern_sequencer.
// With LED_SEQ_PAUSE_EN defined the pause scenario is also exercised.
module tb_led_rgb_pattern_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW_W  = 32;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [AW:0]     num_steps = '0;
  logic            loop_en = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
`ifdef LED_SEQ_PAUSE_EN
  logic            pause = 1'b0;
`endif
  logic [2:0]      enable_rgb;
  logic [2:0]      mode_rgb;
  logic [DW_W-1:0] duration;
  logic [AW-1:0]   step_idx;
  logic            busy;
  logic            done;

  int n_cmp = 0;
  int n_err = 0;

  int lp_idx [16] = '{0,0,0,0,0,1,1,1,0,0,0,0,0,1,1,1};
  int lw_en  [15] = '{1,1,1,1,1,6,6,6,1,1,1,1,1,3,3};
  int lw_dur [15] = '{100,100,100,100,100,50,50,50,100,100,100,100,100,77,77};

  led_rgb_pattern_sequencer_if #(.AW(AW), .DW_W(DW_W)) tbl_if ();

  led_rgb_pattern_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW_W(DW_W)) dut (
    .aclk_i       (aclk),
    .aresetn_i    (aresetn),
    .tbl_if       (tbl_if.slave),
    .num_steps_i  (num_steps),
    .loop_en_i    (loop_en),
    .start_i      (start),
    .stop_i       (stop),
`ifdef LED_SEQ_PAUSE_EN
    .pause_i      (pause),
`endif
    .enable_rgb_o (enable_rgb),
    .mode_rgb_o   (mode_rgb),
    .duration_o   (duration),
    .step_idx_o   (step_idx),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr_entry(input logic [AW-1:0] a, input logic [2:0] en, input logic [2:0] md,
                          input logic [DW_W-1:0] dur, input logic [DW_W-1:0] dw);
    tbl_if.tbl_wr       = 1'b1;
    tbl_if.tbl_addr     = a;
    tbl_if.tbl_en       = en;
    tbl_if.tbl_mode     = md;
    tbl_if.tbl_duration = dur;
    tbl_if.tbl_dwell    = dw;
    tick();
    tbl_if.tbl_wr       = 1'b0;
  endtask

  task automatic load_basic();
    wr_entry(4'd0, 3'b001, 3'b000, 32'd100, 32'd4);
    wr_entry(4'd1, 3'b110, 3'b010, 32'd50, 32'd2);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++;
    if ({enable_rgb, mode_rgb, step_idx, busy, done} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_init outs=%h exp=000", {enable_rgb, mode_rgb, step_idx, busy, done});
    end
    n_cmp++;
    if (duration !== '0) begin
      n_err++;
      $display("FAIL reset_init_dur got=%0d exp=0", duration);
    end
    aresetn = 1'b1;
    tick();
    load_basic();
    num_steps = 5'd2;
    loop_en   = 1'b1;
    pulse_start();
    tick();
    tick();
    n_cmp++;
    if ({enable_rgb, busy} !== {3'b001, 1'b1}) begin
      n_err++;
      $display("FAIL reset_prerun en=%b busy=%b exp en=001 busy=1", enable_rgb, busy);
    end
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if ({enable_rgb, mode_rgb, step_idx, busy, done} !== 12'h000 || duration !== '0) begin
      n_err++;
      $display("FAIL reset_async outs=%h dur=%0d exp 000/0",
               {enable_rgb, mode_rgb, step_idx, busy, done}, duration);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
        n_err++;
        $display("FAIL reset_hold c=%0d busy=%b done=%b exp 0 0", c, busy, done);
      end
    end
    loop_en = 1'b0;
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [11:0]     exp_v;
    logic [DW_W-1:0] exp_d;
    load_basic();
    num_steps = 5'd2;
    loop_en   = 1'b0;
    pulse_start();
    n_cmp++;
    if ({busy, done, enable_rgb} !== 5'b10_000) begin
      n_err++;
      $display("FAIL basic_load busy=%b done=%b en=%b exp 1 0 000", busy, done, enable_rgb);
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c <= 5) begin
        exp_v = {3'b001, 3'b000, 4'd0, 1'b1, 1'b0};
        exp_d = 32'd100;
      end else if (c <= 7) begin
        exp_v = {3'b110, 3'b010, 4'd1, 1'b1, 1'b0};
        exp_d = 32'd50;
      end else begin
        exp_v = {3'b110, 3'b010, 4'd1, 1'b0, 1'b1};
        exp_d = 32'd50;
      end
      n_cmp++;
      if ({enable_rgb, mode_rgb, step_idx, busy, done} !== exp_v || duration !== exp_d) begin
        n_err++;
        $display("FAIL basic_run c=%0d outs=%h dur=%0d exp outs=%h dur=%0d", c,
                 {enable_rgb, mode_rgb, step_idx, busy, done}, duration, exp_v, exp_d);
      end
    end
    tick();
    n_cmp++;
    if ({busy, done, enable_rgb} !== 5'b00_110) begin
      n_err++;
      $display("FAIL basic_after busy=%b done=%b en=%b exp 0 0 110", busy, done, enable_rgb);
    end
  endtask

  task automatic test_loop();
    loop_en = 1'b1;
    pulse_start();
    for (int c = 1; c <= 16; c++) begin
      tick();
      n_cmp++;
      if ({step_idx, busy, done} !== {AW'(lp_idx[c-1]), (c < 16), (c == 16)}) begin
        n_err++;
        $display("FAIL loop_seq c=%0d idx=%0d busy=%b done=%b exp idx=%0d busy=%0d done=%0d",
                 c, step_idx, busy, done, lp_idx[c-1], (c < 16), (c == 16));
      end
      if (c == 9) loop_en = 1'b0;
    end
    n_cmp++;
    if (enable_rgb !== 3'b110) begin
      n_err++;
      $display("FAIL loop_hold en=%b exp 110", enable_rgb);
    end
  endtask

  task automatic test_boundaries();
    num_steps = 5'd0;
    pulse_start();
    n_cmp++;
    if ({busy, done, enable_rgb} !== 5'b01_110) begin
      n_err++;
      $display("FAIL zero_steps busy=%b done=%b en=%b exp 0 1 110", busy, done, enable_rgb);
    end
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL zero_steps_after busy=%b done=%b exp 0 0", busy, done);
    end

    wr_entry(4'd0, 3'b100, 3'b111, 32'd7, 32'd0);
    num_steps = 5'd1;
    loop_en   = 1'b0;
    pulse_start();
    tick();
    n_cmp++;
    if ({enable_rgb, mode_rgb, busy, done} !== {3'b100, 3'b111, 1'b1, 1'b0} || duration !== 32'd7) begin
      n_err++;
      $display("FAIL dwell0_run en=%b mode=%b busy=%b done=%b dur=%0d exp 100 111 1 0 7",
               enable_rgb, mode_rgb, busy, done, duration);
    end
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      n_err++;
      $display("FAIL dwell0_end busy=%b done=%b exp 0 1", busy, done);
    end

    for (int i = 0; i < DEPTH; i++)
      wr_entry(AW'(i), 3'(i), 3'b000, 32'(1000 + i), 32'd1);
    num_steps = 5'd16;
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      n_cmp++;
      if (step_idx !== AW'(i) || duration !== 32'(1000 + i) || enable_rgb !== 3'(i) || busy !== 1'b1) begin
        n_err++;
        $display("FAIL full_depth i=%0d idx=%0d dur=%0d en=%b busy=%b exp idx=%0d dur=%0d",
                 i, step_idx, duration, enable_rgb, busy, i, 1000 + i);
      end
      if (i < DEPTH - 1) tick();
    end
    tick();
    n_cmp++;
    if ({step_idx, busy, done} !== {4'd15, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL full_depth_end idx=%0d busy=%b done=%b exp 15 0 1", step_idx, busy, done);
    end
  endtask

  task automatic test_stop();
    load_basic();
    num_steps = 5'd2;
    loop_en   = 1'b0;
    pulse_start();
    repeat (6) tick();
    n_cmp++;
    if ({enable_rgb, step_idx} !== {3'b110, 4'd1}) begin
      n_err++;
      $display("FAIL stop_pre en=%b idx=%0d exp 110 1", enable_rgb, step_idx);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++;
    if ({enable_rgb, mode_rgb, step_idx, busy, done} !== 12'h000 || duration !== '0) begin
      n_err++;
      $display("FAIL stop_clear outs=%h dur=%0d exp 000/0",
               {enable_rgb, mode_rgb, step_idx, busy, done}, duration);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
        n_err++;
        $display("FAIL stop_nodone c=%0d busy=%b done=%b exp 0 0", c, busy, done);
      end
    end

    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL start_stop busy=%b done=%b exp 0 0", busy, done);
    end
    tick();
    n_cmp++;
    if ({busy, enable_rgb} !== 4'b0_000) begin
      n_err++;
      $display("FAIL start_stop_after busy=%b en=%b exp 0 000", busy, enable_rgb);
    end

    pulse_start();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({enable_rgb, step_idx, busy} !== {3'b001, 4'd0, 1'b1}) begin
      n_err++;
      $display("FAIL busy_start en=%b idx=%0d busy=%b exp 001 0 1", enable_rgb, step_idx, busy);
    end
    repeat (4) tick();
    n_cmp++;
    if ({enable_rgb, busy, done} !== {3'b110, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL busy_start_mid en=%b busy=%b done=%b exp 110 1 0", enable_rgb, busy, done);
    end
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      n_err++;
      $display("FAIL busy_start_end busy=%b done=%b exp 0 1", busy, done);
    end
  endtask

  task automatic test_live_write();
    load_basic();
    num_steps = 5'd2;
    loop_en   = 1'b1;
    pulse_start();
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 7) tbl_if.tbl_wr = 1'b0;
      n_cmp++;
      if (enable_rgb !== 3'(lw_en[c-1]) || duration !== 32'(lw_dur[c-1])) begin
        n_err++;
        $display("FAIL live_write c=%0d en=%b dur=%0d exp en=%0d dur=%0d",
                 c, enable_rgb, duration, lw_en[c-1], lw_dur[c-1]);
      end
      if (c == 6) begin
        tbl_if.tbl_wr       = 1'b1;
        tbl_if.tbl_addr     = 4'd1;
        tbl_if.tbl_en       = 3'b011;
        tbl_if.tbl_mode     = 3'b001;
        tbl_if.tbl_duration = 32'd77;
        tbl_if.tbl_dwell    = 32'd2;
      end
    end
    n_cmp++;
    if (mode_rgb !== 3'b001) begin
      n_err++;
      $display("FAIL live_write_mode mode=%b exp 001", mode_rgb);
    end
    stop = 1'b1;
    tick();
    stop    = 1'b0;
    loop_en = 1'b0;
    tick();
  endtask

`ifdef LED_SEQ_PAUSE_EN
  task automatic test_pause();
    load_basic();
    num_steps = 5'd2;
    loop_en   = 1'b0;
    pulse_start();
    for (int c = 1; c <= 16; c++) begin
      tick();
      n_cmp++;
      if ({enable_rgb, busy} !== {((c <= 15) ? 3'b001 : 3'b110), 1'b1}) begin
        n_err++;
        $display("FAIL pause_hold c=%0d en=%b busy=%b exp en=%s busy=1",
                 c, enable_rgb, busy, (c <= 15) ? "001" : "110");
      end
      if (c == 1)  pause = 1'b1;
      if (c == 11) pause = 1'b0;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask
`endif

  initial begin
    tbl_if.tbl_wr       = 1'b0;
    tbl_if.tbl_addr     = '0;
    tbl_if.tbl_en       = '0;
    tbl_if.tbl_mode     = '0;
    tbl_if.tbl_duration = '0;
    tbl_if.tbl_dwell    = '0;
    test_reset();
    test_basic();
    test_loop();
    test_boundaries();
    test_stop();
    test_live_write();
`ifdef LED_SEQ_PAUSE_EN
    test_pause();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
